fpmul_arbiter: RTL and testbench

Shares one combinational IEEE-754 single-precision multiplier (`mult`) between `N_REQ` requesters. Round-robin arbitration picks one request per cycle. Operands are registered in front of the multiplier, and results are registered behind it, so the shared datapath runs at full throughput with backpressure. Each result returns on a common response channel, tagged with the requester index.

---
 rtl/fpmul_arbiter_if.sv | 27 ++
 rtl/fpmul_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_fpmul_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpmul_arbiter_if.sv
// Request/response bundle between N_REQ requesters and the shared FP multiplier arbiter.
// master = requester/consumer side, slave = arbiter side.
interface fpmul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_result;
  logic                rsp_overflow;
  logic                rsp_underflow;
  logic                rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow
  );
endinterface

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision multiplier (mult) between N_REQ requesters.
// Optional per-requester grant counters are built when FPMUL_ARB_STATS_EN is defined.

module mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);
  logic              sign;
  logic [7:0]        ea, eb;
  logic [47:0]       prod;
  logic [23:0]       mant;
  logic              guard, sticky;
  logic signed [9:0] exp;
  logic              a_nan, b_nan;

  function automatic logic [24:0] round_rne(input logic [22:0] frac, input logic g, input logic s);
    logic [24:0] r;
    r = {2'b01, frac};
    if (g && (s || frac[0])) r = r + 25'd1;
    return r;
  endfunction

  always_comb begin
    logic [24:0] rnd;
    sign      = a[31] ^ b[31];
    ea        = a[30:23];
    eb        = b[30:23];
    a_nan     = (&ea) && (|a[22:0]);
    b_nan     = (&eb) && (|b[22:0]);
    prod      = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    exp       = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    result    = 32'h0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (prod[47]) begin
      guard  = prod[23];
      sticky = |prod[22:0];
      rnd    = round_rne(prod[46:24], guard, sticky);
      exp    = exp + 10'sd1;
    end else begin
      guard  = prod[22];
      sticky = |prod[21:0];
      rnd    = round_rne(prod[45:23], guard, sticky);
    end
    // Rounding carry out of the hidden bit renormalises to 1.0 x 2^(exp+1)
    mant = rnd[23:0];
    if (rnd[24]) begin
      mant = 24'h800000;
      exp  = exp + 10'sd1;
    end
    if (a_nan || b_nan) begin
      result = 32'h7FC00000;
    end else if ((&ea) || (&eb)) begin
      result = ((ea == 8'd0) || (eb == 8'd0)) ? 32'h7FC00000 : {sign, 8'hFF, 23'h0};
    end else if ((ea == 8'd0) || (eb == 8'd0)) begin
      result = {sign, 31'h0};
    end else if (exp >= 10'sd255) begin
      overflow = 1'b1;
      result   = {sign, 8'hFF, 23'h0};
    end else if (exp <= 10'sd0) begin
      underflow = 1'b1;
      result    = {sign, 31'h0};
    end else begin
      result = {sign, exp[7:0], mant[22:0]};
    end
  end
endmodule

module fpmul_arbiter #(
  parameter int  N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef FPMUL_ARB_STATS_EN
  input  logic                stat_clr,
  output logic [N_REQ*16-1:0] stat_grants,
`endif
  fpmul_arbiter_if.slave      bus
);
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] grant;
  logic            stall, s1_adv, accept;

  logic            s1_valid;
  logic [31:0]     s1_a, s1_b;
  logic [ID_W-1:0] s1_id;

  logic [31:0]     m_result;
  logic            m_ovf, m_unf;

  logic            s2_valid;
  logic [ID_W-1:0] s2_id;
  logic [31:0]     s2_result;
  logic            s2_ovf, s2_unf;

  assign stall  = s2_valid & ~bus.rsp_ready;
  assign s1_adv = ~s1_valid | ~stall;
  assign accept = (|bus.req_valid) & s1_adv;

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        grant = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
  end

  // S1: granted operands and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      last     <= ID_W'(N_REQ - 1);
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_a  <= bus.req_a[{grant, 5'd0} +: 32];
          s1_b  <= bus.req_b[{grant, 5'd0} +: 32];
          s1_id <= grant;
        end
      end
      if (accept) last <= grant;
    end
  end

  mult u_mult (
    .a         (s1_a),
    .b         (s1_b),
    .result    (m_result),
    .overflow  (m_ovf),
    .underflow (m_unf)
  );

  // S2: product, flags and tag driving the response channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      s2_result <= '0;
      s2_ovf    <= 1'b0;
      s2_unf    <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id     <= s1_id;
        s2_result <= m_result;
        s2_ovf    <= m_ovf;
        s2_unf    <= m_unf;
      end
    end
  end

  assign bus.rsp_valid     = s2_valid;
  assign bus.rsp_id        = s2_id;
  assign bus.rsp_result    = s2_result;
  assign bus.rsp_overflow  = s2_ovf;
  assign bus.rsp_underflow = s2_unf;

`ifdef FPMUL_ARB_STATS_EN
  logic [15:0] grants_q [N_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) grants_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (stat_clr) grants_q[i] <= '0;
        else if (bus.req_ready[i] && (grants_q[i] != 16'hFFFF)) grants_q[i] <= grants_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) stat_grants[16*i +: 16] = grants_q[i];
  end
`endif
endmodule

// File: tb/tb_fpmul_arbiter.sv
// Randomized bench for fpmul_arbiter: real-arithmetic product model plus an in-flight scoreboard.
module tb_fpmul_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpmul_arbiter_if #(.N_REQ(N)) bus ();

`ifdef FPMUL_ARB_STATS_EN
  logic          stat_clr;
  logic [N*16-1:0] stat_grants;
`endif

  fpmul_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef FPMUL_ARB_STATS_EN
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants),
`endif
    .bus         (bus)
  );

  typedef struct {
    int          id;
    logic [33:0] r;
    int          cyc;
  } item_t;

  item_t       sb[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          last_m = N - 1;
  int          acc_cnt = 0;
  int          g0_cnt = 0;
  logic        pend [N];
  logic [31:0] pa [N];
  logic [31:0] pb [N];
  logic        rr;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_rsp = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Product of two normal floats via exact double multiply, then round-to-nearest-even to single.
  function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    real         ra, rb, p;
    logic [63:0] bits;
    int          fe;
    logic [23:0] m;
    logic        s;
    ra   = $bitstoreal({a[31], 11'(int'(a[30:23]) - 127 + 1023), a[22:0], 29'h0});
    rb   = $bitstoreal({b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'h0});
    p    = ra * rb;
    bits = $realtobits(p);
    s    = a[31] ^ b[31];
    fe   = int'(bits[62:52]) - 1023 + 127;
    m    = {1'b0, bits[51:29]};
    if (bits[28] && ((|bits[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m  = '0;
      fe = fe + 1;
    end
    if (fe >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (fe <= 0)   return {2'b01, s, 31'h0};
    return {2'b00, s, 8'(fe), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_norm();
    return {1'($urandom), 8'($urandom_range(189, 64)), 23'($urandom)};
  endfunction

  function automatic int next_grant();
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last_m + i) % N;
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0] exp_ready;
    logic         ev;
    int           g;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]       = pend[i];
      bus.req_a[32*i +: 32]  = pa[i];
      bus.req_b[32*i +: 32]  = pb[i];
    end
    bus.rsp_ready = rr;
    #1;
    exp_ready = '0;
    g = next_grant();
    if (g >= 0 && (sb.size() < 2 || rr)) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    ev = (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    if (bus.rsp_valid && ev) begin
      chk("rsp_id", 64'(bus.rsp_id), 64'(sb[0].id));
      chk("rsp_result", 64'(bus.rsp_result), 64'(sb[0].r[31:0]));
      chk("rsp_flags", 64'({bus.rsp_overflow, bus.rsp_underflow}), 64'(sb[0].r[33:32]));
    end
    if (prev_stall)
      chk("rsp_hold", {bus.rsp_valid, 29'h0, bus.rsp_overflow, bus.rsp_underflow,
                       bus.rsp_id, bus.rsp_result}, prev_rsp);
    if (bus.req_ready != '0) acc_cnt++;
    if (bus.rsp_valid && ev && rr) void'(sb.pop_front());
    if (exp_ready != '0) begin
      sb.push_back('{id: g, r: ref_mul(pa[g], pb[g]), cyc: cyc});
      last_m  = g;
      pend[g] = 1'b0;
      if (g == 0) g0_cnt++;
    end
    prev_stall = bus.rsp_valid && !rr;
    prev_rsp   = {bus.rsp_valid, 29'h0, bus.rsp_overflow, bus.rsp_underflow,
                  bus.rsp_id, bus.rsp_result};
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
  endtask

  task automatic drain();
    rr = 1'b1;
    for (int k = 0; k < 40 && (sb.size() > 0 || (|{pend[0], pend[1], pend[2], pend[3]})); k++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);
    step();
  endtask

  task automatic check_reset_outputs();
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_rsp_flags", 64'({bus.rsp_overflow, bus.rsp_underflow}), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
  endtask

  initial begin
    int seen;
    rst_n         = 1'b0;
    rr            = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
`ifdef FPMUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pa[i]   = '0;
      pb[i]   = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single request: 2.0 * 1.0
    set_req(0, 32'h40000000, 32'h3F800000);
    step();
    drain();

    // Round-robin with all requesters continuously valid
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, rand_norm(), rand_norm());
      step();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain();

    // Operand routing, then overflow and underflow products
    set_req(2, 32'h40200000, 32'h40600000);
    set_req(3, 32'hBF800000, 32'h40000000);
    step();
    step();
    set_req(1, 32'h7F000000, 32'h40000000);
    set_req(0, 32'h00800000, 32'h3F000000);
    drain();

    // Backpressure: requester 1 streams while rsp_ready is held low
    rr = 1'b0;
    seen = acc_cnt;
    for (int c = 0; c < 5; c++) begin
      if (!pend[1]) set_req(1, rand_norm(), rand_norm());
      step();
    end
    chk("bp_accepts", 64'(acc_cnt - seen), 64'd2);
    pend[1] = 1'b0;
    drain();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(99) < 40) set_req(i, rand_norm(), rand_norm());
      rr = ($urandom_range(3) != 0);
      step();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain();

    // Reset mid-flight with S1 and S2 full
    rr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (!pend[1]) set_req(1, rand_norm(), rand_norm());
      step();
    end
    chk("pipe_full", 64'(sb.size()), 64'd2);
    @(negedge clk);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    last_m     = N - 1;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr    = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, rand_norm(), rand_norm());
    step();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drain();

`ifdef FPMUL_ARB_STATS_EN
    // Grant counter saturation and clear
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    g0_cnt = 0;
    rr = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      if (!pend[0]) set_req(0, rand_norm(), rand_norm());
      step();
      if (c == 999) chk("stat_mid", 64'(stat_grants[15:0]), 64'(g0_cnt));
    end
    pend[0] = 1'b0;
    drain();
    chk("stat_sat", 64'(stat_grants[15:0]), 64'((g0_cnt > 65535) ? 65535 : g0_cnt));
    chk("stat_others", 64'(stat_grants[63:16]), 64'd0);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    chk("stat_clr", 64'(stat_grants), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
